// File: rtl/mux_key_reverse_search_pkg.sv
// Shared types for the reverse key search: scan FSM state encoding.
package mux_key_reverse_search_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } search_state_e;

endpackage

// File: rtl/mux_key_reverse_search_table.sv
// Key/data table with per-entry valid bits, a single write/clear port and an
// asynchronous read by index. Only the valid bits are reset.
module mux_key_table #(
   parameter int NR_KEY   = 4,
   parameter int KEY_LEN  = 2,
   parameter int DATA_LEN = 8,
   parameter int IDX_W    = $clog2(NR_KEY)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                wr_en,
   input  logic [IDX_W-1:0]    wr_idx,
   input  logic [KEY_LEN-1:0]  wr_key,
   input  logic [DATA_LEN-1:0] wr_data,
   input  logic [IDX_W-1:0]    rd_idx,
   output logic                rd_valid,
   output logic [KEY_LEN-1:0]  rd_key,
   output logic [DATA_LEN-1:0] rd_data
);

   logic [NR_KEY-1:0]   valid_q, valid_d;
   logic [KEY_LEN-1:0]  key_q  [NR_KEY];
   logic [KEY_LEN-1:0]  key_d  [NR_KEY];
   logic [DATA_LEN-1:0] data_q [NR_KEY];
   logic [DATA_LEN-1:0] data_d [NR_KEY];
   logic                wr_in_range;

   assign wr_in_range = ({1'b0, wr_idx} < (IDX_W + 1)'(NR_KEY));

   // Clear is applied before the write so a combined clr+write leaves one valid entry.
   always_comb begin
      valid_d = valid_q;
      key_d   = key_q;
      data_d  = data_q;
      if (clr) begin
         valid_d = {NR_KEY{1'b0}};
      end else begin
         valid_d = valid_q;
      end
      if (wr_en && wr_in_range) begin
         valid_d[wr_idx] = 1'b1;
         key_d[wr_idx]   = wr_key;
         data_d[wr_idx]  = wr_data;
      end else begin
         key_d  = key_q;
         data_d = data_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= {NR_KEY{1'b0}};
      end else begin
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      key_q  <= key_d;
      data_q <= data_d;
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_key   = key_q[rd_idx];
   assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/mux_key_reverse_search.sv
// Sequential reverse lookup: scans the table one entry per cycle and returns
// the key of the lowest-index valid entry whose data equals the request.
module mux_key_reverse_search
   import mux_key_reverse_search_pkg::*;
#(
   parameter int NR_KEY      = 4,
   parameter int KEY_LEN     = 2,
   parameter int DATA_LEN    = 8,
   parameter int HAS_DEFAULT = 0,
   localparam int IDX_W      = $clog2(NR_KEY)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                wr_en,
   input  logic [IDX_W-1:0]    wr_idx,
   input  logic [KEY_LEN-1:0]  wr_key,
   input  logic [DATA_LEN-1:0] wr_data,
   output logic                wr_ready,
   input  logic [KEY_LEN-1:0]  default_key,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [DATA_LEN-1:0] req_data,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic                resp_hit,
   output logic [KEY_LEN-1:0]  resp_key,
   output logic [IDX_W-1:0]    resp_idx,
   output logic                busy
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_KEY - 1);

   search_state_e       state_q, state_d;
   logic [IDX_W-1:0]    scan_idx_q, scan_idx_d;
   logic [DATA_LEN-1:0] req_data_q, req_data_d;
   logic [KEY_LEN-1:0]  dflt_key_q, dflt_key_d;
   logic                hit_q, hit_d;
   logic [KEY_LEN-1:0]  key_q, key_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                idle_q, idle_d;
   logic                resp_valid_q, resp_valid_d;
   logic                busy_q, busy_d;

   logic                ent_valid;
   logic [KEY_LEN-1:0]  ent_key;
   logic [DATA_LEN-1:0] ent_data;
   logic                ent_match;

   // The table is writable only while idle, so it is frozen during a scan.
   mux_key_table #(
      .NR_KEY   (NR_KEY),
      .KEY_LEN  (KEY_LEN),
      .DATA_LEN (DATA_LEN),
      .IDX_W    (IDX_W)
   ) u_table (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr & idle_q),
      .wr_en    (wr_en & idle_q),
      .wr_idx   (wr_idx),
      .wr_key   (wr_key),
      .wr_data  (wr_data),
      .rd_idx   (scan_idx_q),
      .rd_valid (ent_valid),
      .rd_key   (ent_key),
      .rd_data  (ent_data)
   );

   assign ent_match = ent_valid && (ent_data == req_data_q);

   always_comb begin
      state_d    = state_q;
      scan_idx_d = scan_idx_q;
      req_data_d = req_data_q;
      dflt_key_d = dflt_key_q;
      hit_d      = hit_q;
      key_d      = key_q;
      idx_d      = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d    = ST_SCAN;
               scan_idx_d = {IDX_W{1'b0}};
               req_data_d = req_data;
               dflt_key_d = default_key;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (ent_match) begin
               state_d = ST_DONE;
               hit_d   = 1'b1;
               key_d   = ent_key;
               idx_d   = scan_idx_q;
            end else if (scan_idx_q == LAST_IDX) begin
               state_d = ST_DONE;
               hit_d   = 1'b0;
               idx_d   = {IDX_W{1'b0}};
               key_d   = (HAS_DEFAULT != 0) ? dflt_key_q : {KEY_LEN{1'b0}};
            end else begin
               scan_idx_d = scan_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
            end
         end
         ST_DONE: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Status outputs are registered copies of the next-state decode.
      idle_d       = (state_d == ST_IDLE);
      resp_valid_d = (state_d == ST_DONE);
      busy_d       = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         scan_idx_q   <= {IDX_W{1'b0}};
         req_data_q   <= {DATA_LEN{1'b0}};
         dflt_key_q   <= {KEY_LEN{1'b0}};
         hit_q        <= 1'b0;
         key_q        <= {KEY_LEN{1'b0}};
         idx_q        <= {IDX_W{1'b0}};
         idle_q       <= 1'b1;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         scan_idx_q   <= scan_idx_d;
         req_data_q   <= req_data_d;
         dflt_key_q   <= dflt_key_d;
         hit_q        <= hit_d;
         key_q        <= key_d;
         idx_q        <= idx_d;
         idle_q       <= idle_d;
         resp_valid_q <= resp_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign wr_ready   = idle_q;
   assign req_ready  = idle_q;
   assign resp_valid = resp_valid_q;
   assign resp_hit   = hit_q;
   assign resp_key   = key_q;
   assign resp_idx   = idx_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_mux_key_reverse_search.sv
// Bench for mux_key_reverse_search: two instances (HAS_DEFAULT 0 and 1) share
// stimulus and are checked against an array model of the table.
module tb_mux_key_reverse_search;

   localparam int NK = 4;

   logic       clk = 1'b0;
   logic       rst, clr, wr_en, req_valid, resp_ready;
   logic [1:0] wr_idx, wr_key, default_key;
   logic [7:0] wr_data, req_data;

   logic       wr_ready0, req_ready0, resp_valid0, resp_hit0, busy0;
   logic [1:0] resp_key0, resp_idx0;
   logic       wr_ready1, req_ready1, resp_valid1, resp_hit1, busy1;
   logic [1:0] resp_key1, resp_idx1;

   int vectors = 0;
   int errors  = 0;

   bit         m_valid [NK];
   logic [1:0] m_key   [NK];
   logic [7:0] m_data  [NK];

   always #5 clk = ~clk;

   mux_key_reverse_search #(.NR_KEY(NK), .KEY_LEN(2), .DATA_LEN(8), .HAS_DEFAULT(0)) dut0 (
      .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
      .wr_data(wr_data), .wr_ready(wr_ready0), .default_key(default_key),
      .req_valid(req_valid), .req_ready(req_ready0), .req_data(req_data),
      .resp_valid(resp_valid0), .resp_ready(resp_ready), .resp_hit(resp_hit0),
      .resp_key(resp_key0), .resp_idx(resp_idx0), .busy(busy0));

   mux_key_reverse_search #(.NR_KEY(NK), .KEY_LEN(2), .DATA_LEN(8), .HAS_DEFAULT(1)) dut1 (
      .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
      .wr_data(wr_data), .wr_ready(wr_ready1), .default_key(default_key),
      .req_valid(req_valid), .req_ready(req_ready1), .req_data(req_data),
      .resp_valid(resp_valid1), .resp_ready(resp_ready), .resp_hit(resp_hit1),
      .resp_key(resp_key1), .resp_idx(resp_idx1), .busy(busy1));

   // Reference: first valid entry holding d wins; a miss walks the whole table.
   function automatic void model_search(input logic [7:0] d, output bit hit,
                                        output logic [1:0] key, output logic [1:0] idx,
                                        output int lat);
      hit = 1'b0; key = 2'd0; idx = 2'd0; lat = NK + 1;
      for (int i = 0; i < NK; i++) begin
         if (!hit && m_valid[i] && m_data[i] == d) begin
            hit = 1'b1; key = m_key[i]; idx = 2'(i); lat = i + 2;
         end
      end
   endfunction

   task automatic write(input bit c, input bit w, input logic [1:0] i,
                        input logic [1:0] k, input logic [7:0] d);
      bit accepted;
      clr = c; wr_en = w; wr_idx = i; wr_key = k; wr_data = d;
      accepted = (wr_ready0 === 1'b1);
      @(posedge clk); #1;
      clr = 1'b0; wr_en = 1'b0;
      if (accepted) begin
         if (c) for (int j = 0; j < NK; j++) m_valid[j] = 1'b0;
         if (w) begin
            m_valid[i] = 1'b1; m_key[i] = k; m_data[i] = d;
         end
      end
   endtask

   task automatic search(input logic [7:0] d, input logic [1:0] dk,
                         output logic o_hit, output logic [1:0] o_key,
                         output logic [1:0] o_idx, output int o_lat);
      bit e_hit; logic [1:0] e_key, e_idx; int e_lat; int n;
      model_search(d, e_hit, e_key, e_idx, e_lat);
      req_data = d; default_key = dk; req_valid = 1'b1;
      vectors++;
      if (req_ready0 !== 1'b1 || req_ready1 !== 1'b1) begin
         errors++; $display("FAIL req_ready_idle: got %b/%b want 1", req_ready0, req_ready1);
      end
      @(posedge clk); #1;
      req_valid = 1'b0; default_key = ~dk;
      vectors++;
      if (busy0 !== 1'b1 || req_ready0 !== 1'b0) begin
         errors++; $display("FAIL busy_in_scan: busy=%b req_ready=%b want 1/0", busy0, req_ready0);
      end
      n = 1;
      while (resp_valid0 !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      vectors++;
      if (n != e_lat || resp_valid1 !== 1'b1) begin
         errors++; $display("FAIL latency data=%h: got %0d (v1=%b) want %0d", d, n, resp_valid1, e_lat);
      end
      vectors++;
      if (resp_hit0 !== e_hit || resp_key0 !== e_key || resp_idx0 !== e_idx) begin
         errors++; $display("FAIL result_nodflt data=%h: got hit=%b key=%0d idx=%0d want hit=%b key=%0d idx=%0d",
                            d, resp_hit0, resp_key0, resp_idx0, e_hit, e_key, e_idx);
      end
      vectors++;
      if (resp_hit1 !== e_hit || resp_key1 !== (e_hit ? e_key : dk) || resp_idx1 !== e_idx) begin
         errors++; $display("FAIL result_dflt data=%h: got hit=%b key=%0d idx=%0d want hit=%b key=%0d idx=%0d",
                            d, resp_hit1, resp_key1, resp_idx1, e_hit, (e_hit ? e_key : dk), e_idx);
      end
      o_hit = resp_hit0; o_key = resp_key0; o_idx = resp_idx0; o_lat = n;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      vectors++;
      if (resp_valid0 !== 1'b0 || req_ready0 !== 1'b1 || busy0 !== 1'b0) begin
         errors++; $display("FAIL return_idle: valid=%b ready=%b busy=%b want 0/1/0",
                            resp_valid0, req_ready0, busy0);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int j = 0; j < NK; j++) m_valid[j] = 1'b0;
      vectors++;
      if (wr_ready0 !== 1'b1 || req_ready0 !== 1'b1 || resp_valid0 !== 1'b0 || busy0 !== 1'b0 ||
          resp_hit0 !== 1'b0 || resp_key0 !== 2'd0 || resp_idx0 !== 2'd0) begin
         errors++; $display("FAIL reset_state: wr_rdy=%b req_rdy=%b valid=%b busy=%b hit=%b key=%0d idx=%0d",
                            wr_ready0, req_ready0, resp_valid0, busy0, resp_hit0, resp_key0, resp_idx0);
      end
   endtask

   task automatic test_basic_hit();
      logic h; logic [1:0] k, i; int l;
      write(1'b0, 1'b1, 2'd0, 2'd1, 8'h10);
      write(1'b0, 1'b1, 2'd1, 2'd2, 8'h20);
      write(1'b0, 1'b1, 2'd2, 2'd3, 8'h30);
      write(1'b0, 1'b1, 2'd3, 2'd0, 8'h40);
      search(8'h30, 2'd0, h, k, i, l);
      vectors++;
      if (h !== 1'b1 || k !== 2'd3 || i !== 2'd2 || l != 4) begin
         errors++; $display("FAIL hit_0x30: got hit=%b key=%0d idx=%0d lat=%0d want 1/3/2/4", h, k, i, l);
      end
   endtask

   task automatic test_priority_and_miss();
      logic h; logic [1:0] k, i; int l;
      write(1'b0, 1'b1, 2'd3, 2'd0, 8'h20);
      search(8'h20, 2'd0, h, k, i, l);
      vectors++;
      if (h !== 1'b1 || k !== 2'd2 || i !== 2'd1 || l != 3) begin
         errors++; $display("FAIL dup_priority: got hit=%b key=%0d idx=%0d lat=%0d want 1/2/1/3", h, k, i, l);
      end
      search(8'h99, 2'b11, h, k, i, l);
      vectors++;
      if (h !== 1'b0 || k !== 2'd0 || i !== 2'd0 || l != 5) begin
         errors++; $display("FAIL miss_nodflt: got hit=%b key=%0d idx=%0d lat=%0d want 0/0/0/5", h, k, i, l);
      end
      vectors++;
      if (resp_key1 !== 2'd3) begin
         errors++; $display("FAIL miss_dflt_key: got %0d want 3", resp_key1);
      end
   endtask

   task automatic test_backpressure();
      logic h; logic [1:0] k, i; int l;
      req_data = 8'h10; default_key = 2'd0; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      l = 0;
      while (resp_valid0 !== 1'b1 && l < 20) begin @(posedge clk); #1; l++; end
      for (int c = 0; c < 6; c++) begin
         clr = 1'b0; wr_en = 1'b1; wr_idx = 2'd0; wr_key = 2'd2; wr_data = 8'h77;
         vectors++;
         if (resp_valid0 !== 1'b1 || resp_hit0 !== 1'b1 || resp_key0 !== 2'd1 || resp_idx0 !== 2'd0 ||
             req_ready0 !== 1'b0 || wr_ready0 !== 1'b0) begin
            errors++; $display("FAIL backpressure_hold c=%0d: valid=%b hit=%b key=%0d idx=%0d rdy=%b wrdy=%b",
                               c, resp_valid0, resp_hit0, resp_key0, resp_idx0, req_ready0, wr_ready0);
         end
         @(posedge clk); #1;
      end
      wr_en = 1'b0; resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      vectors++;
      if (req_ready0 !== 1'b1 || resp_valid0 !== 1'b0) begin
         errors++; $display("FAIL backpressure_release: rdy=%b valid=%b want 1/0", req_ready0, resp_valid0);
      end
      search(8'h77, 2'd0, h, k, i, l);
      vectors++;
      if (h !== 1'b0) begin
         errors++; $display("FAIL blocked_write_ignored: got hit=%b want 0", h);
      end
   endtask

   task automatic test_clr_write();
      logic h; logic [1:0] k, i; int l;
      write(1'b1, 1'b1, 2'd1, 2'd2, 8'h55);
      search(8'h55, 2'd0, h, k, i, l);
      vectors++;
      if (h !== 1'b1 || i !== 2'd1 || k !== 2'd2) begin
         errors++; $display("FAIL clr_write_hit: got hit=%b idx=%0d key=%0d want 1/1/2", h, i, k);
      end
      search(8'h10, 2'd0, h, k, i, l);
      vectors++;
      if (h !== 1'b0) begin
         errors++; $display("FAIL clr_old_miss: got hit=%b want 0", h);
      end
   endtask

   task automatic test_reset_mid_scan();
      logic h; logic [1:0] k, i; int l; bit seen;
      write(1'b0, 1'b1, 2'd3, 2'd1, 8'h66);
      req_data = 8'h66; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int j = 0; j < NK; j++) m_valid[j] = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < NK + 4; c++) begin
         if (resp_valid0 !== 1'b0 || resp_valid1 !== 1'b0) seen = 1'b1;
         @(posedge clk); #1;
      end
      vectors++;
      if (seen) begin
         errors++; $display("FAIL reset_abort: resp_valid seen=1 want 0");
      end
      search(8'h66, 2'd0, h, k, i, l);
      vectors++;
      if (h !== 1'b0) begin
         errors++; $display("FAIL reset_invalidates: got hit=%b want 0", h);
      end
   endtask

   task automatic test_random();
      logic h; logic [1:0] k, i; int l;
      logic [7:0] d;
      for (int it = 0; it < 40; it++) begin
         write(($urandom_range(0, 9) == 0), 1'b1, 2'($urandom_range(0, 3)),
               2'($urandom), 8'($urandom_range(0, 7)));
         if ($urandom_range(0, 1) == 1) d = m_data[$urandom_range(0, 3)];
         else d = 8'($urandom_range(0, 9));
         search(d, 2'($urandom), h, k, i, l);
      end
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_idx = 2'd0; wr_key = 2'd0; wr_data = 8'h00;
      default_key = 2'd0; req_valid = 1'b0; req_data = 8'h00; resp_ready = 1'b0;
      for (int j = 0; j < NK; j++) begin m_valid[j] = 1'b0; m_key[j] = 2'd0; m_data[j] = 8'h00; end
      test_reset();
      test_basic_hit();
      test_priority_and_miss();
      test_backpressure();
      test_clr_write();
      test_reset_mid_scan();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/mux_key_reverse_search.md
Name: mux_key_reverse_search

Overview:
- Sequential reverse lookup over a loadable key/data table: given a data value, returns the key of the lowest-index valid entry whose data matches.
- Complements the combinational key->data selector templates: same key/data pairing and HAS_DEFAULT semantics, opposite direction.
- Used in npc for decode-back paths (e.g. value -> code tables) where a full parallel CAM is too costly; scans one entry per cycle.

Parameters:
- NR_KEY, 4, number of table entries (>=2; need not be a power of two).
- KEY_LEN, 2, key width.
- DATA_LEN, 8, data width.
- HAS_DEFAULT, 0, 1: a miss returns default_key; 0: a miss returns key 0.
- IDX_W (localparam), $clog2(NR_KEY), entry index width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- clr  input  1  invalidates all entries; honoured only when wr_ready=1.
- wr_en  input  1  write entry wr_idx; honoured only when wr_ready=1.
- wr_idx  input  IDX_W  entry index; writes with wr_idx>=NR_KEY are ignored.
- wr_key  input  KEY_LEN  key to store.
- wr_data  input  DATA_LEN  data to store.
- wr_ready  output  1  high only in IDLE.
- default_key  input  KEY_LEN  miss value when HAS_DEFAULT=1; sampled when a request is accepted.
- req_valid  input  1  search request.
- req_ready  output  1  high only in IDLE.
- req_data  input  DATA_LEN  value to search for; captured on acceptance.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts the result.
- resp_hit  output  1  a match was found.
- resp_key  output  KEY_LEN  matched key, or the miss value.
- resp_idx  output  IDX_W  matched index; 0 on a miss.
- busy  output  1  high when the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - FSM goes to IDLE and all entry valid bits clear.
  - resp_valid=0, resp_hit=0, resp_key=0, resp_idx=0, busy=0.
  - req_ready=1 and wr_ready=1 in the first cycle after reset.
- Reset mid-search aborts the search with no response. Stored key/data need no reset; only the valid bits do.
- FSM states: IDLE, SCAN, DONE.
  - IDLE -> SCAN on req_valid&req_ready. Latch req_data and default_key; scan index is 0.
  - SCAN: each cycle, compare the entry at the scan index (valid && data==latched data).
    - On a match: capture hit=1, key and idx, then go to DONE.
    - On no match at index NR_KEY-1: capture hit=0, idx=0, key=(HAS_DEFAULT ? latched default_key : 0), then go to DONE.
    - Otherwise increment the scan index.
  - DONE: resp_valid=1 and resp_* are held stable. On resp_ready, go to IDLE; resp_valid drops the next cycle.
- Latency, with acceptance in cycle T:
  - Hit at index k: resp_valid first high in cycle T+k+2.
  - Miss: resp_valid first high in cycle T+NR_KEY+1.
- Throughput: one request per search. A new request is accepted in the cycle after the DONE->IDLE handshake.
- Priority: the lowest matching index wins; later duplicates are never returned.
- Write port:
  - Writes are accepted only in IDLE, so the table is frozen during a search.
  - clr and wr_en in the same cycle: clr is applied first, then the write, so the written entry ends valid and all others invalid.
  - Write and request accepted in the same IDLE cycle: the write is visible to that search, because the compare happens from T+1.
- resp_key/resp_idx/resp_hit hold their last value outside DONE.

Decomposition:
- Shared package (npc ips package): FSM state enum {IDLE, SCAN, DONE}.
- One sub-module, mux_key_table: NR_KEY registers of {valid, key, data} with a write/clear port and an asynchronous read by index.
- The top level holds the FSM, the scan counter and the result registers.

Test Plan:
- After reset, the bench checks wr_ready=1, req_ready=1, resp_valid=0 and busy=0. It then writes {0:K=1,D=0x10},{1:K=2,D=0x20},{2:K=3,D=0x30},{3:K=0,D=0x40}. A search for 0x30 accepted in cycle T must give resp_valid in T+4 with hit=1, key=3, idx=2.
- Duplicate priority: write entry 3 with D=0x20 and search for 0x20 -> hit=1, idx=1, key=2, resp_valid at T+3.
- Miss, with the same table:
  - HAS_DEFAULT=0: a search for 0x99 -> resp_valid at T+5, hit=0, key=0, idx=0.
  - HAS_DEFAULT=1 with default_key=2'b11 -> key=3, and the key stays 3 even if default_key changes mid-search.
- Backpressure: hold resp_ready=0 for 6 cycles in DONE -> resp_* stable, req_ready=0, and a wr_en during this time is ignored (table unchanged). Raise resp_ready -> IDLE the next cycle.
- clr with a simultaneous write (clr=1, wr_en=1, idx=1, D=0x55) -> a search for 0x55 hits idx=1, and a search for 0x10 misses.
- Assert rst during SCAN -> no resp_valid ever appears for that request, all entries become invalid, and any search then misses.
